regif2tlp: RTL and testbench
============================

REGIF2TLP -- requirements
Module: regif2tlp

Interface
REQ-001 The module SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth on snd_resp (legal values 2..4).
REQ-002 The module SHALL have parameter RESP_TC, default 3'b000, giving the traffic class placed in every emitted TLP header.
REQ-003 clk  in  1  sole clock; all logic is on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 snd_resp  in  1  level request from the register-access engine; asynchronous to clk.
REQ-006 resp  in  64  response word {code[63:32], data[31:0]}; stable while snd_resp is high.
REQ-007 snd_resp_ack  out  1  level acknowledge for the four-phase handshake.
REQ-008 host_addr  in  64  host DMA address for the response; bits [2:0] are ignored.
REQ-009 host_addr_vld  in  1  host_addr has been programmed.
REQ-010 cfg_completer_id  in  16  requester ID {bus, dev, func}.
REQ-011 my_trn  in  1  TX arbiter grant.
REQ-012 drv_trn  out  1  block owns the TRN TX interface.
REQ-013 trn_td  out  64  TX data; [63:32] is the first DW.
REQ-014 trn_trem_n  out  8  remainder; 8'h00 = both DWs valid, 8'h0F = only [63:32] valid.
REQ-015 trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n  out  1 each  active-low start-of-frame, end-of-frame, source-ready.
REQ-016 trn_tdst_rdy_n  in  1  active-low core ready.
REQ-017 drop_cnt  out  16  number of responses discarded because host_addr_vld was low.

Function
REQ-018 snd_resp SHALL pass through a SYNC_STAGES-flop synchronizer; only the synchronized value snd_resp_s is used internally.
REQ-019 FSM states SHALL be IDLE, ARB, QW0, QW1, QW2, ACK and REL.
- IDLE: on snd_resp_s=1, latch resp, host_addr and the header format; go to ARB if host_addr_vld=1, else increment drop_cnt and go to ACK.
- ARB: on my_trn=1, set drv_trn=1 and go to QW0.
- QW0/QW1/QW2: one TRN beat per state; advance only on a beat transfer.
- ACK: set snd_resp_ack=1 and go to REL.
- REL: when snd_resp_s=0, clear snd_resp_ack and go to IDLE.
REQ-020 A beat SHALL transfer on a cycle where trn_tsrc_rdy_n=0 and trn_tdst_rdy_n=0. trn_tsrc_rdy_n SHALL be 0 in all of QW0..QW2. trn_td, trn_trem_n, trn_tsof_n and trn_teof_n SHALL hold while trn_tdst_rdy_n=1.
REQ-021 The header format SHALL be 3DW (fmt 2'b10) when latched host_addr[63:32]==0, else 4DW (fmt 2'b11).
REQ-022 Header fields:
- DW0 = {1'b0, fmt, 5'b00000, 1'b0, RESP_TC, 4'b0, TD=0, EP=0, attr 2'b00, 2'b00, length 10'd2}.
- DW1 = {cfg_completer_id, tag[7:0], lastBE 4'hF, firstBE 4'hF}.
REQ-023 Payload word P0 SHALL be the byte-swap of resp[31:0], i.e. {resp[7:0], resp[15:8], resp[23:16], resp[31:24]}; P1 SHALL be the byte-swap of resp[63:32].
REQ-024 3DW beats:
- QW0 = {DW0, DW1}, tsof_n=0.
- QW1 = {addr[31:3], 3'b000, P0}.
- QW2 = {P1, 32'h0}, trem_n=8'h0F, teof_n=0.
REQ-025 4DW beats:
- QW0 = {DW0, DW1}, tsof_n=0.
- QW1 = {addr[63:32], addr[31:3], 3'b000}.
- QW2 = {P0, P1}, trem_n=8'h00, teof_n=0.
REQ-026 On the QW2 transfer, the FSM SHALL clear drv_trn and trn_tsrc_rdy_n (to 1), increment tag (8-bit, 8'hFF wraps to 8'h00) and go to ACK.
REQ-027 drop_cnt SHALL saturate at 16'hFFFF.
REQ-028 If my_trn drops during QW0..QW2, the frame SHALL still complete; the arbiter does not pre-empt.
REQ-029 A new request SHALL be accepted only after REL returns to IDLE. snd_resp_s high in IDLE on the cycle after REL SHALL start a new transaction.
REQ-030 Changes to host_addr or host_addr_vld after latching SHALL NOT affect the frame in flight.

Reset
REQ-031 While rst=1:
- FSM = IDLE, synchronizer = 0, tag = 0, drop_cnt = 0.
- snd_resp_ack = 0, drv_trn = 0.
- trn_tsrc_rdy_n = trn_tsof_n = trn_teof_n = 1, trn_trem_n = 8'h00, trn_td = 0.
REQ-032 Reset asserted mid-frame SHALL abandon the frame immediately; no further beats SHALL be driven after reset deasserts until a new request arrives.

Verification
REQ-033 3DW: host_addr=64'h0000_0000_1234_5678, resp=64'h0000_0001_AABB_CCDD, my_trn=1, tdst_rdy_n=0 -> beats:
- QW0 {32'h4000_0002, {id, 8'h00, 8'hFF}}.
- QW1 {32'h1234_5678, 32'hDDCC_BBAA}.
- QW2 {32'h0100_0000, 32'h0}, trem_n=8'h0F.
Then snd_resp_ack rises.
REQ-034 4DW: host_addr=64'h0000_0001_0000_0040 -> QW0 DW0=32'h6000_0002, QW1={32'h1, 32'h40}, QW2 trem_n=8'h00, teof_n=0 only on QW2.
REQ-035 Backpressure: tdst_rdy_n=1 for 5 cycles during QW1 -> trn_td/trem_n/sof/eof held constant; exactly 3 transfers occur.
REQ-036 host_addr_vld=0 with snd_resp=1 -> no TRN activity, drop_cnt 0->1, ack completes; drop_cnt preloaded to 16'hFFFF stays 16'hFFFF.
REQ-037 256 back-to-back handshakes -> tag sequence 0..255 then 0; snd_resp_ack falls only after snd_resp falls.
REQ-038 rst pulsed during QW1 -> all outputs at reset values asynchronously; the next request emits a clean full frame with tag=0.

Source files
------------

// File: rtl/regif2tlp.sv
// Bridges a four-phase register-engine response onto TRN TX as a 3DW/4DW memory-write TLP.
// Beats are driven combinationally from the FSM state, so they hold naturally under trn_tdst_rdy_n.
module regif2tlp #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [2:0]  RESP_TC     = 3'b000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        snd_resp,
  input  logic [63:0] resp,
  output logic        snd_resp_ack,
  input  logic [63:0] host_addr,
  input  logic        host_addr_vld,
  input  logic [15:0] cfg_completer_id,
  input  logic        my_trn,
  output logic        drv_trn,
  output logic [63:0] trn_td,
  output logic [7:0]  trn_trem_n,
  output logic        trn_tsof_n,
  output logic        trn_teof_n,
  output logic        trn_tsrc_rdy_n,
  input  logic        trn_tdst_rdy_n,
  output logic [15:0] drop_cnt
);

  typedef enum logic [2:0] {IDLE, ARB, QW0, QW1, QW2, ACK, REL} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   snd_resp_s;
  logic [63:0]            resp_q, resp_d;
  logic [63:0]            addr_q, addr_d;
  logic                   fmt4_q, fmt4_d;
  logic [7:0]             tag_q, tag_d;
  logic [15:0]            drop_q, drop_d;
  logic                   ack_q, ack_d;
  logic                   drv_q, drv_d;
  logic                   in_qw;
  logic                   beat_xfer;
  logic [31:0]            dw0, dw1, p0, p1;
  logic                   unused_addr_bits;

  // Low address bits are dropped: the payload is always QW aligned.
  assign unused_addr_bits = ^host_addr[2:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], snd_resp};
  end
  assign snd_resp_s = sync_q[SYNC_STAGES-1];

  assign in_qw     = (state_q == QW0) || (state_q == QW1) || (state_q == QW2);
  assign beat_xfer = in_qw && !trn_tdst_rdy_n;

  always_comb begin
    state_d = state_q;
    resp_d  = resp_q;
    addr_d  = addr_q;
    fmt4_d  = fmt4_q;
    tag_d   = tag_q;
    drop_d  = drop_q;
    ack_d   = ack_q;
    drv_d   = drv_q;
    case (state_q)
      IDLE: begin
        if (snd_resp_s) begin
          resp_d = resp;
          addr_d = {host_addr[63:3], 3'b000};
          fmt4_d = |host_addr[63:32];
          if (host_addr_vld) begin
            state_d = ARB;
          end else begin
            if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
            state_d = ACK;
          end
        end
      end
      ARB: begin
        if (my_trn) begin
          drv_d   = 1'b1;
          state_d = QW0;
        end
      end
      QW0: if (beat_xfer) state_d = QW1;
      QW1: if (beat_xfer) state_d = QW2;
      QW2: begin
        if (beat_xfer) begin
          drv_d   = 1'b0;
          tag_d   = tag_q + 8'd1;
          state_d = ACK;
        end
      end
      ACK: begin
        ack_d   = 1'b1;
        state_d = REL;
      end
      REL: begin
        if (!snd_resp_s) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      resp_q  <= '0;
      addr_q  <= '0;
      fmt4_q  <= 1'b0;
      tag_q   <= '0;
      drop_q  <= '0;
      ack_q   <= 1'b0;
      drv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
      addr_q  <= addr_d;
      fmt4_q  <= fmt4_d;
      tag_q   <= tag_d;
      drop_q  <= drop_d;
      ack_q   <= ack_d;
      drv_q   <= drv_d;
    end
  end

  assign dw0 = {1'b0, 1'b1, fmt4_q, 5'b00000, 1'b0, RESP_TC, 4'b0000,
                1'b0, 1'b0, 2'b00, 2'b00, 10'd2};
  assign dw1 = {cfg_completer_id, tag_q, 4'hF, 4'hF};
  assign p0  = {resp_q[7:0],   resp_q[15:8],  resp_q[23:16], resp_q[31:24]};
  assign p1  = {resp_q[39:32], resp_q[47:40], resp_q[55:48], resp_q[63:56]};

  always_comb begin
    trn_td         = '0;
    trn_trem_n     = 8'h00;
    trn_tsof_n     = 1'b1;
    trn_teof_n     = 1'b1;
    trn_tsrc_rdy_n = 1'b1;
    case (state_q)
      QW0: begin
        trn_td         = {dw0, dw1};
        trn_tsof_n     = 1'b0;
        trn_tsrc_rdy_n = 1'b0;
      end
      QW1: begin
        trn_td         = fmt4_q ? addr_q : {addr_q[31:0], p0};
        trn_tsrc_rdy_n = 1'b0;
      end
      QW2: begin
        trn_td         = fmt4_q ? {p0, p1} : {p1, 32'h0};
        trn_trem_n     = fmt4_q ? 8'h00 : 8'h0F;
        trn_teof_n     = 1'b0;
        trn_tsrc_rdy_n = 1'b0;
      end
      default: ;
    endcase
  end

  assign snd_resp_ack = ack_q;
  assign drv_trn      = drv_q;
  assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_regif2tlp.sv
// Directed and randomized frames on regif2tlp, checked against a field-level TLP model.
module tb_regif2tlp;
  logic        clk = 1'b0;
  logic        rst;
  logic        snd_resp;
  logic [63:0] resp;
  logic        snd_resp_ack;
  logic [63:0] host_addr;
  logic        host_addr_vld;
  logic [15:0] cfg_completer_id;
  logic        my_trn;
  logic        drv_trn;
  logic [63:0] trn_td;
  logic [7:0]  trn_trem_n;
  logic        trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n;
  logic        trn_tdst_rdy_n;
  logic [15:0] drop_cnt;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [63:0] exp_td   [3];
  logic [7:0]  exp_trem [3];
  logic [7:0]  tag_m;
  logic [15:0] drop_m;

  always #5 clk = ~clk;

  regif2tlp dut (
    .clk(clk), .rst(rst), .snd_resp(snd_resp), .resp(resp), .snd_resp_ack(snd_resp_ack),
    .host_addr(host_addr), .host_addr_vld(host_addr_vld), .cfg_completer_id(cfg_completer_id),
    .my_trn(my_trn), .drv_trn(drv_trn), .trn_td(trn_td), .trn_trem_n(trn_trem_n),
    .trn_tsof_n(trn_tsof_n), .trn_teof_n(trn_teof_n), .trn_tsrc_rdy_n(trn_tsrc_rdy_n),
    .trn_tdst_rdy_n(trn_tdst_rdy_n), .drop_cnt(drop_cnt)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(3-i) +: 8];
    return r;
  endfunction

  // Expected frame built from the TLP field definitions.
  task automatic model(input logic [63:0] ha, input logic [63:0] rs, input logic [7:0] tg);
    logic [63:0] a;
    logic [31:0] dw0, dw1, p0, p1;
    bit          four;
    a    = ha & ~64'h7;
    four = (ha >> 32) != 64'd0;
    dw0  = (four ? 32'd3 : 32'd2) * 32'h2000_0000 + 32'd2;
    dw1  = {cfg_completer_id, tg, 8'hFF};
    p0   = bswap(rs[31:0]);
    p1   = bswap(rs[63:32]);
    exp_td[0]   = {dw0, dw1};
    exp_trem[0] = 8'h00;
    exp_trem[1] = 8'h00;
    if (four) begin
      exp_td[1] = a;
      exp_td[2] = {p0, p1};
      exp_trem[2] = 8'h00;
    end else begin
      exp_td[1] = {a[31:0], p0};
      exp_td[2] = {p1, 32'h0};
      exp_trem[2] = 8'h0F;
    end
  endtask

  function automatic logic [127:0] reset_vec();
    return {54'd0, 1'b0, 1'b0, 64'd0, 8'h00, 1'b1, 1'b1, 1'b1};
  endfunction

  function automatic logic [127:0] out_vec();
    return {54'd0, snd_resp_ack, drv_trn, trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n};
  endfunction

  // One full handshake; called and returns at a falling edge.
  task automatic do_frame(input logic [63:0] ha, input logic [63:0] rs, input logic vld,
                          input int bp_len, input bit rnd);
    int          beats = 0;
    int          stall_cnt = 0;
    bit          held = 0;
    bit          stall;
    logic [74:0] prev = '0;
    int          idx;
    host_addr = ha; host_addr_vld = vld; resp = rs; snd_resp = 1'b1;
    my_trn = 1'b1; trn_tdst_rdy_n = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      if (held) check("hold", {53'd0, trn_td, trn_trem_n, trn_tsof_n, trn_teof_n}, {53'd0, prev});
      held = 0;
      check("drv_vs_src", {127'd0, drv_trn}, {127'd0, ~trn_tsrc_rdy_n});
      if (drv_trn) begin
        host_addr = {$urandom, $urandom};
        host_addr_vld = 1'($urandom_range(0, 1));
      end
      if (snd_resp_ack) break;
      my_trn = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!trn_tsrc_rdy_n) begin
        stall = 0;
        if (beats == 1 && stall_cnt < bp_len) begin stall = 1; stall_cnt++; end
        else if (rnd && $urandom_range(0, 3) == 0) stall = 1;
        trn_tdst_rdy_n = stall;
        if (stall) begin
          prev = {trn_td, trn_trem_n, trn_tsof_n, trn_teof_n};
          held = 1;
        end else begin
          idx = (beats > 2) ? 2 : beats;
          check($sformatf("beat%0d", beats),
                {53'd0, trn_td, trn_trem_n, trn_tsof_n, trn_teof_n},
                {53'd0, exp_td[idx], exp_trem[idx], 1'(idx != 0), 1'(idx != 2)});
          beats++;
        end
      end else begin
        trn_tdst_rdy_n = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
    check("ack_rise", {127'd0, snd_resp_ack}, 128'd1);
    check("beat_count", 128'(beats), vld ? 128'd3 : 128'd0);
    for (int h = $urandom_range(0, 3); h > 0; h--) begin
      @(negedge clk);
      check("ack_hold", {127'd0, snd_resp_ack}, 128'd1);
    end
    snd_resp = 1'b0;
    for (int cyc = 0; cyc < 20 && snd_resp_ack; cyc++) @(negedge clk);
    check("ack_fall", {127'd0, snd_resp_ack}, 128'd0);
    if (vld) tag_m = tag_m + 8'd1;
    else if (drop_m != 16'hFFFF) drop_m = drop_m + 16'd1;
    check("drop_cnt", {112'd0, drop_cnt}, {112'd0, drop_m});
  endtask

  task automatic rand_frame(input bit allow_drop);
    logic [63:0] ha, rs;
    logic        v;
    ha = {($urandom_range(0, 1) != 0) ? $urandom : 32'h0, $urandom};
    rs = {$urandom, $urandom};
    v  = allow_drop ? ($urandom_range(0, 3) != 0) : 1'b1;
    cfg_completer_id = 16'($urandom);
    model(ha, rs, tag_m);
    do_frame(ha, rs, v, 0, 1);
  endtask

  initial begin
    bit quiet;
    rst = 1'b1; snd_resp = 1'b0; resp = '0; host_addr = '0; host_addr_vld = 1'b0;
    cfg_completer_id = 16'hBEEF; my_trn = 1'b0; trn_tdst_rdy_n = 1'b1;
    tag_m = 8'd0; drop_m = 16'd0;
    repeat (3) @(negedge clk);
    check("reset_outputs", out_vec(), reset_vec());
    check("reset_drop", {112'd0, drop_cnt}, 128'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed 3DW frame.
    exp_td[0] = {32'h4000_0002, 16'hBEEF, 8'h00, 8'hFF};
    exp_td[1] = 64'h1234_5678_DDCC_BBAA;
    exp_td[2] = 64'h0100_0000_0000_0000;
    exp_trem[0] = 8'h00; exp_trem[1] = 8'h00; exp_trem[2] = 8'h0F;
    do_frame(64'h0000_0000_1234_5678, 64'h0000_0001_AABB_CCDD, 1'b1, 0, 0);

    // Directed 4DW frame.
    exp_td[0] = {32'h6000_0002, 16'hBEEF, 8'h01, 8'hFF};
    exp_td[1] = 64'h0000_0001_0000_0040;
    exp_td[2] = 64'h8877_6655_4433_2211;
    exp_trem[2] = 8'h00;
    do_frame(64'h0000_0001_0000_0040, 64'h1122_3344_5566_7788, 1'b1, 0, 0);

    // Five stall cycles on QW1.
    model(64'h0000_0000_8000_1007, 64'hCAFE_F00D_0BAD_BEEF, tag_m);
    do_frame(64'h0000_0000_8000_1007, 64'hCAFE_F00D_0BAD_BEEF, 1'b1, 5, 0);

    // Drops, including saturation.
    do_frame(64'h0000_0000_0000_1000, 64'h1, 1'b0, 0, 0);
    force dut.drop_q = 16'hFFFE;
    @(negedge clk);
    release dut.drop_q;
    drop_m = 16'hFFFE;
    do_frame(64'h0000_0000_0000_1000, 64'h2, 1'b0, 0, 0);
    do_frame(64'h0000_0000_0000_1000, 64'h3, 1'b0, 0, 0);

    for (int i = 0; i < 24; i++) rand_frame(1);

    // Reset in the middle of QW1.
    host_addr = 64'h0000_0000_0000_2000; host_addr_vld = 1'b1; resp = 64'h55;
    my_trn = 1'b1; trn_tdst_rdy_n = 1'b0; snd_resp = 1'b1;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(negedge clk);
      if (!trn_tsrc_rdy_n && trn_tsof_n) break;
    end
    check("reach_qw1", {126'd0, trn_tsrc_rdy_n, trn_tsof_n}, 128'd1);
    trn_tdst_rdy_n = 1'b1;
    #2 rst = 1'b1;
    #1 check("async_reset", out_vec(), reset_vec());
    snd_resp = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    tag_m = 8'd0; drop_m = 16'd0;
    quiet = 1;
    repeat (6) begin
      @(negedge clk);
      if (!trn_tsrc_rdy_n || drv_trn || snd_resp_ack) quiet = 0;
    end
    check("quiet_after_reset", {127'd0, quiet}, 128'd1);
    cfg_completer_id = 16'h0123;
    model(64'h0000_0000_0000_3008, 64'h0102_0304_0506_0708, tag_m);
    do_frame(64'h0000_0000_0000_3008, 64'h0102_0304_0506_0708, 1'b1, 0, 0);

    // Tag wrap over 257 back-to-back handshakes from reset.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tag_m = 8'd0; drop_m = 16'd0;
    @(negedge clk);
    for (int i = 0; i < 257; i++) rand_frame(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
